// File: rtl/wmul_pkg.sv
// Shared constants and types for the sequential wide multiplier.
//   A_W         : multiplicand width
//   CHUNK_W     : width of one multiplier chunk per pass
//   state_e     : controller states
//   chunk_count : number of CHUNK_W-bit chunks needed to cover a w-bit value
package wmul_pkg;

  localparam int A_W     = 149;
  localparam int CHUNK_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_MUL   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  function automatic int chunk_count(input int w);
    return (w + CHUNK_W - 1) / CHUNK_W;
  endfunction

endpackage

// File: rtl/mult_149x16.sv
// 149x16 unsigned multiplier with one registered output stage.
// Ports:
//   clk : clock
//   a_i : 149-bit multiplicand
//   b_i : 16-bit multiplier chunk
//   p_o : registered product, valid one cycle after a_i/b_i
// The output register carries no reset; the consumer qualifies it with its
// own valid pipeline.
module mult_149x16
  import wmul_pkg::*;
(
  input  logic                     clk,
  input  logic [A_W-1:0]           a_i,
  input  logic [CHUNK_W-1:0]       b_i,
  output logic [A_W+CHUNK_W-1:0]   p_o
);

  always_ff @(posedge clk) begin
    p_o <= a_i * b_i;
  end

endmodule

// File: rtl/wide_mult_seq.sv
// Sequential wide multiplier: in_a (149 bits) times in_b (B_W bits), built
// from N_CHUNK passes through a single 149x16 multiplier with shift-add
// accumulation.
// Ports:
//   clk       : clock, rising edge
//   rst_n     : asynchronous active-low reset
//   in_valid  : operands presented
//   in_ready  : operands accepted this cycle (high only in IDLE)
//   in_a      : multiplicand, unsigned
//   in_b      : multiplier, unsigned
//   out_valid : out_p holds a finished product (DONE)
//   out_ready : consumer takes out_p
//   out_p     : unsigned product
//   busy      : high in every state except IDLE
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | waiting for operands, in_ready high
// ST_MUL   | feeding chunk k of b into the multiplier, k = 0..N_CHUNK-1
// ST_DRAIN | last partial product leaving the multiplier register
// ST_DONE  | product held on out_p until out_ready
module wide_mult_seq
  import wmul_pkg::*;
#(
  parameter  int B_W     = 149,
  localparam int N_CHUNK = chunk_count(B_W)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [A_W-1:0]     in_a,
  input  logic [B_W-1:0]     in_b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [A_W+B_W-1:0] out_p,
  output logic               busy
);

  localparam int B_EXT_W = CHUNK_W * N_CHUNK;
  localparam int ACC_W   = A_W + B_EXT_W;
  localparam int P_W     = A_W + B_W;
  localparam int PROD_W  = A_W + CHUNK_W;
  localparam int CNT_W   = $clog2(N_CHUNK) + 1;
  localparam logic [CNT_W-1:0] K_LAST = CNT_W'(N_CHUNK - 1);

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     k_q, k_d;
  logic [CNT_W-1:0]     kd_q;
  logic                 pv_q;
  logic [A_W-1:0]       a_q;
  logic [B_W-1:0]       b_q;
  logic [ACC_W-1:0]     acc_q;

  logic                 accept;
  logic [B_EXT_W-1:0]   b_ext;
  logic [CHUNK_W-1:0]   mul_b;
  logic [PROD_W-1:0]    prod;
  logic [ACC_W-1:0]     partial;

  assign accept = in_valid && in_ready;

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          state_d = ST_MUL;
          k_d     = '0;
        end
      end
      ST_MUL: begin
        // Counter parks at 0 on exit so the chunk select never leaves range.
        if (k_q == K_LAST) begin
          state_d = ST_DRAIN;
          k_d     = '0;
        end else begin
          k_d = k_q + CNT_W'(1);
        end
      end
      ST_DRAIN: state_d = ST_DONE;
      ST_DONE: begin
        if (out_ready) state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        k_d     = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      k_q     <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
    end
  end

  assign b_ext = B_EXT_W'(b_q);
  assign mul_b = CHUNK_W'(b_ext >> (CHUNK_W * k_q));

  mult_149x16 u_mult (
    .clk (clk),
    .a_i (a_q),
    .b_i (mul_b),
    .p_o (prod)
  );

  assign partial = ACC_W'(prod) << (CHUNK_W * kd_q);

  // pv_q/kd_q travel alongside the multiplier register. pv_q is reset, so
  // whatever the unreset product register holds after reset is never added.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q   <= '0;
      b_q   <= '0;
      pv_q  <= 1'b0;
      kd_q  <= '0;
      acc_q <= '0;
    end else begin
      pv_q <= (state_q == ST_MUL);
      kd_q <= k_q;
      if (accept) begin
        a_q   <= in_a;
        b_q   <= in_b;
        acc_q <= '0;
      end else if (pv_q) begin
        acc_q <= acc_q + partial;
      end
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign busy      = (state_q != ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign out_p     = acc_q[P_W-1:0];

endmodule

// File: tb/tb_wide_mult_seq.sv
module tb_wide_mult_seq;

  localparam int A_W = 149;
  localparam int B_W = 149;
  localparam int P_W = A_W + B_W;

  logic           clk;
  logic           rst_n;
  logic           in_valid;
  logic           in_ready;
  logic [A_W-1:0] in_a;
  logic [B_W-1:0] in_b;
  logic           out_valid;
  logic           out_ready;
  logic [P_W-1:0] out_p;
  logic           busy;

  int tests = 0;
  int fails = 0;

  wide_mult_seq #(.B_W(B_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_p     (out_p),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #3_000_000;
    $display("FAIL watchdog: observed no finish expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [P_W-1:0] obs, input logic [P_W-1:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [A_W-1:0] a, input logic [B_W-1:0] b);
    int n;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) chk("send_timeout", P_W'(in_ready), P_W'(1));
    in_a     = a;
    in_b     = b;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  // Edges counted from the accepting edge until out_valid is seen.
  task automatic wait_done(output int edges);
    edges = 0;
    while (!out_valid && edges < 60) begin
      @(posedge clk);
      #1;
      edges++;
    end
    if (!out_valid) chk("done_timeout", P_W'(out_valid), P_W'(1));
  endtask

  task automatic collect(input int stall, output logic [P_W-1:0] p);
    p = out_p;
    out_ready = 1'b0;
    repeat (stall) begin
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  initial begin
    int             edges;
    int             busy_bad;
    int             stable_bad;
    logic [P_W-1:0] p;
    logic [P_W-1:0] exp;
    logic [P_W-1:0] held;
    logic [A_W-1:0] ra;
    logic [B_W-1:0] rb;
    int             mode;
    int             stall;

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_a      = '0;
    in_b      = '0;
    out_ready = 1'b0;

    #3;
    chk("reset_out_valid", P_W'(out_valid), P_W'(0));
    chk("reset_busy", P_W'(busy), P_W'(0));
    chk("reset_out_p", out_p, '0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("reset_in_ready", P_W'(in_ready), P_W'(1));

    // 1 x 1, latency, busy, and an in_valid pulse mid-operation that must be ignored
    send(149'd1, 149'd1);
    edges    = 0;
    busy_bad = 0;
    while (!out_valid && edges < 60) begin
      if (edges == 3) begin
        in_valid = 1'b1;
        in_a     = 149'd7;
        in_b     = 149'd7;
      end else begin
        in_valid = 1'b0;
      end
      if (!busy) busy_bad++;
      @(posedge clk);
      #1;
      edges++;
    end
    in_valid = 1'b0;
    chk("one_latency", P_W'(edges), P_W'(11));
    chk("one_busy_cycles", P_W'(busy_bad), P_W'(0));
    chk("one_product", out_p, P_W'(1));
    collect(0, p);
    chk("one_back_idle", P_W'(busy), P_W'(0));

    // all-ones squared: 2^298 - 2^150 + 1 truncated to 298 bits
    send({A_W{1'b1}}, {B_W{1'b1}});
    wait_done(edges);
    exp = {{148{1'b1}}, {149{1'b0}}, 1'b1};
    chk("max_latency", P_W'(edges), P_W'(11));
    chk("max_product", out_p, exp);
    chk("max_upper_zero", P_W'(dut.acc_q >> P_W), P_W'(0));
    collect(0, p);

    // only chunk 9 of b nonzero
    rb = '0;
    rb[144] = 1'b1;
    send(149'h1234, rb);
    wait_done(edges);
    exp = P_W'(16'h1234) << 144;
    chk("chunk9_product", out_p, exp);
    collect(0, p);

    // zero operand: same latency, zero result
    send('0, {B_W{1'b1}});
    wait_done(edges);
    chk("zero_latency", P_W'(edges), P_W'(11));
    chk("zero_product", out_p, '0);
    collect(0, p);

    // long stall in DONE with in_valid pulses; 0xABCD * 0x11 = 747677
    send(149'hABCD, 149'h11);
    wait_done(edges);
    chk("stall_product", out_p, P_W'(747677));
    held       = out_p;
    stable_bad = 0;
    for (int i = 0; i < 20; i++) begin
      in_valid = i[0];
      in_a     = 149'd9;
      in_b     = 149'd9;
      @(posedge clk);
      #1;
      if (out_valid !== 1'b1 || out_p !== held || busy !== 1'b1) stable_bad++;
    end
    chk("stall_stable", P_W'(stable_bad), P_W'(0));
    in_valid  = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    chk("release_busy", P_W'(busy), P_W'(0));
    chk("release_in_ready", P_W'(in_ready), P_W'(1));
    chk("release_out_valid", P_W'(out_valid), P_W'(0));
    @(posedge clk);
    #1;
    chk("release_no_accept", P_W'(busy), P_W'(0));

    // reset in MUL at k=5
    send(149'd3, 149'd7);
    repeat (5) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_busy", P_W'(busy), P_W'(0));
    chk("midrst_out_valid", P_W'(out_valid), P_W'(0));
    chk("midrst_out_p", out_p, '0);
    chk("midrst_in_ready", P_W'(in_ready), P_W'(1));
    @(negedge clk);
    rst_n = 1'b1;
    send(149'd3, 149'd5);
    wait_done(edges);
    chk("postrst_latency", P_W'(edges), P_W'(11));
    chk("postrst_product", out_p, P_W'(15));
    collect(0, p);

    // random back-to-back transactions with occasional out_ready stalls
    for (int t = 0; t < 1000; t++) begin
      ra   = A_W'({$urandom, $urandom, $urandom, $urandom, $urandom});
      rb   = B_W'({$urandom, $urandom, $urandom, $urandom, $urandom});
      mode = $urandom_range(0, 5);
      if (mode == 1) ra = A_W'($urandom);
      if (mode == 2) rb = B_W'($urandom_range(0, 65535));
      if (mode == 3) rb = '0;
      if (mode == 4) ra = {A_W{1'b1}};
      stall = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 5) : 0;
      exp   = P_W'(ra) * P_W'(rb);
      send(ra, rb);
      wait_done(edges);
      collect(stall, p);
      chk($sformatf("rand_%0d", t), p, exp);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/wide_mult_seq.md
WIDE_MULT_SEQ -- requirements
Module: wide_mult_seq

Interface
REQ-001 Parameter B_W, default 149: width of operand b; legal range 1..160.
REQ-002 Parameter N_CHUNK, default ceil(B_W/16) = 10: number of 16-bit b chunks; derived, not overridden.
REQ-003 Port clk  input  1: single clock; all state changes on its rising edge.
REQ-004 Port rst_n  input  1: reset, asynchronous, active-low.
REQ-005 Port in_valid  input  1: operands a, b are presented.
REQ-006 Port in_ready  output  1: block accepts operands this cycle.
REQ-007 Port in_a  input  149: multiplicand, unsigned.
REQ-008 Port in_b  input  B_W: multiplier, unsigned.
REQ-009 Port out_valid  output  1: out_p holds a completed product.
REQ-010 Port out_ready  input  1: consumer takes out_p this cycle.
REQ-011 Port out_p  output  149+B_W: unsigned product in_a*in_b.
REQ-012 Port busy  output  1: high in every state except IDLE.

Function
REQ-013 The block SHALL compute in_a*in_b by issuing N_CHUNK passes through one 149x16 multiplier, with b zero-extended to 16*N_CHUNK bits.
REQ-014 The FSM SHALL have states IDLE, MUL, DRAIN, DONE.
REQ-015 in_ready SHALL equal (state==IDLE); an accept is in_valid&&in_ready at a rising edge.
REQ-016 On accept: latch in_a and in_b, clear accumulator and chunk counter, go to MUL.
REQ-017 In MUL with counter k, the multiplier SHALL receive latched a and b[16k+:16]; k increments each cycle; after k==N_CHUNK-1, go to DRAIN.
REQ-018 The multiplier has a one-cycle registered latency; the product of chunk k SHALL be added to the accumulator, shifted left 16k, at the edge following its valid cycle, using a delayed copy of k.
REQ-019 DRAIN SHALL last exactly one cycle, absorb the last partial product, then go to DONE.
REQ-020 out_valid SHALL be high exactly in DONE, first visible after the 11th rising edge following accept (N_CHUNK=10); out_p SHALL be stable while out_valid is high.
REQ-021 DONE SHALL hold until out_ready; then go to IDLE. No new operand is accepted in the same cycle.
REQ-022 Accumulator width SHALL be 149+16*N_CHUNK bits; out_p is its low 149+B_W bits; the truncated upper bits are always zero.
REQ-023 in_valid while busy SHALL be ignored, with no state change.
REQ-024 Operands of zero SHALL follow the normal latency; no early-out.

Reset
REQ-025 While rst_n is low, the block SHALL immediately hold: state IDLE, counter 0, accumulator 0, out_valid 0, busy 0, out_p 0, in_ready 1 after release.
REQ-026 Reset asserted mid-operation SHALL discard the operation without emitting a result; the multiplier's pipeline registers are don't-care after reset and SHALL NOT reach the accumulator.

Structure
REQ-027 Package wmul_pkg SHALL hold A_W=149, CHUNK_W=16, the state enum, and the chunk-count function.
REQ-028 The multiplier SHALL be one instance of the existing mult_149x16; it is the only sub-module.
REQ-029 The shift-add accumulator and FSM SHALL live in wide_mult_seq.

Verification
REQ-030 a=1, b=1 -> out_p=1; out_valid after 11 edges post-accept; busy high for 11 cycles.
REQ-031 a=2^149-1, b=2^149-1 -> out_p=(2^149-1)^2; upper truncated accumulator bits =0.
REQ-032 a=0x1234, b=2^144 (chunk 9 only) -> out_p=0x1234<<144; chunk 0..8 contribute zero.
REQ-033 out_ready held low 20 cycles in DONE -> out_valid and out_p stable; in_valid pulses ignored; release -> IDLE next edge.
REQ-034 rst_n pulsed low in MUL at k=5 -> outputs cleared immediately; a following transaction a=3, b=5 returns 15 with normal latency.
REQ-035 1000 random back-to-back transactions with random out_ready stalls -> every out_p matches the reference model, in order.
